// File: rtl/pitch_synth.sv
// pitch_synth: phase-accumulator tone generator with a click-free envelope.
// Converts a signed frequency word (Hz) into unsigned 8-bit samples, midscale 128.
//
// state     | meaning
// S_IDLE    | silent, phase held at zero, env = 0
// S_ATTACK  | envelope ramping up by ATTACK_STEP per sample
// S_SUSTAIN | envelope held at full scale (255)
// S_RELEASE | envelope ramping down by RELEASE_STEP per sample
module pitch_synth #(
  parameter int SIGNAL_WIDTH  = 8,
  parameter int WIDTH         = 32,
  parameter int PHASE_WIDTH   = 24,
  parameter int SAMPLE_PERIOD = 2272,
  parameter int INC_MULT      = 97582,
  parameter int ATTACK_STEP   = 8,
  parameter int RELEASE_STEP  = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic signed [WIDTH-1:0] freq_in,
  input  logic                    freq_in_valid,
  input  logic [1:0]              wave_sel,
  output logic [SIGNAL_WIDTH-1:0] audio_out,
  output logic                    audio_out_valid,
  output logic                    busy
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ATTACK, S_SUSTAIN, S_RELEASE} state_t;

  state_t                   state, state_cmd, state_next;
  logic [CW-1:0]            cnt;
  logic                     tick, apply_on, apply_off;
  logic                     pend_valid, pend_on;
  logic [PHASE_WIDTH-1:0]   pend_inc, inc, inc_next, phase, phase_next;
  logic [PHASE_WIDTH+7:0]   inc_prod;
  logic [7:0]               env, env_next, p;
  logic [8:0]               env_sum;
  logic signed [9:0]        tri_wave;
  logic signed [7:0]        s;
  logic signed [16:0]       prod, prod_r;
  logic                     prod_valid;

  assign tick      = (cnt == CW'(SAMPLE_PERIOD - 1));
  assign apply_on  = tick & pend_valid & pend_on;
  assign apply_off = tick & pend_valid & ~pend_on;
  // Only the low PHASE_WIDTH+8 product bits can reach the truncated increment.
  assign inc_prod  = (PHASE_WIDTH+8)'($unsigned(freq_in)) * (PHASE_WIDTH+8)'(INC_MULT);
  assign env_sum   = {1'b0, env} + 9'(ATTACK_STEP);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt             <= '0;
      state           <= S_IDLE;
      env             <= '0;
      phase           <= '0;
      inc             <= '0;
      pend_valid      <= 1'b0;
      pend_on         <= 1'b0;
      pend_inc        <= '0;
      prod_r          <= '0;
      prod_valid      <= 1'b0;
      audio_out       <= SIGNAL_WIDTH'(128);
      audio_out_valid <= 1'b0;
      busy            <= 1'b0;
    end else begin
      cnt   <= tick ? '0 : cnt + 1'b1;
      state <= state_next;
      env   <= env_next;
      phase <= phase_next;
      inc   <= inc_next;
      busy  <= (state_next != S_IDLE);
      // A strobe on the tick cycle survives the clear and waits for the next tick.
      if (freq_in_valid) begin
        pend_valid <= 1'b1;
        pend_on    <= (freq_in > 0);
        pend_inc   <= PHASE_WIDTH'(inc_prod >> 8);
      end else if (tick) begin
        pend_valid <= 1'b0;
      end
      prod_valid <= tick;
      if (tick) prod_r <= prod;
      audio_out_valid <= prod_valid;
      if (prod_valid) audio_out <= SIGNAL_WIDTH'(8'(prod_r >>> 8) + 8'd128);
    end
  end

  always_comb begin
    state_cmd = state;
    if (apply_on && (state == S_IDLE || state == S_RELEASE))
      state_cmd = S_ATTACK;
    else if (apply_off && (state == S_ATTACK || state == S_SUSTAIN))
      state_cmd = S_RELEASE;

    env_next = env;
    case (state_cmd)
      S_IDLE:    env_next = 8'd0;
      S_ATTACK:  env_next = env_sum[8] ? 8'hff : env_sum[7:0];
      S_SUSTAIN: env_next = env;
      S_RELEASE: env_next = ({1'b0, env} <= 9'(RELEASE_STEP)) ? 8'd0 : env - 8'(RELEASE_STEP);
      default:   env_next = env;
    endcase

    state_next = state_cmd;
    if (state_cmd == S_ATTACK && env_next == 8'hff)
      state_next = S_SUSTAIN;
    else if (state_cmd == S_RELEASE && env_next == 8'd0)
      state_next = S_IDLE;

    if (!tick) begin
      state_next = state;
      env_next   = env;
    end
  end

  always_comb begin
    inc_next   = apply_on ? pend_inc : inc;
    phase_next = phase;
    if (tick) phase_next = (state_next == S_IDLE) ? '0 : phase + inc_next;
    p = phase_next[PHASE_WIDTH-1 -: 8];
    tri_wave = p[7] ? (10'sd383 - $signed({1'b0, p, 1'b0}))
                    : ($signed({2'b00, p[6:0], 1'b0}) - 10'sd128);
    case (wave_sel)
      2'b00:   s = p[7] ? -8'sd127 : 8'sd127;
      2'b01:   s = $signed(p ^ 8'h80);
      2'b10:   s = 8'(tri_wave);
      default: s = 8'sd0;
    endcase
    prod = s * $signed({1'b0, env_next});
  end

endmodule

// File: tb/tb_pitch_synth.sv
// Bench for pitch_synth: three instances (two short-period, one default) checked
// every cycle against a sample-level reference model, plus directed sample checks.
`timescale 1ns/1ps
module tb_pitch_synth;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [31:0] freq;
  logic               fvalid;
  logic               fvalid_c;
  logic [1:0]         wsel;
  logic [7:0]         audio  [3];
  logic               avalid [3];
  logic               busy_o [3];

  pitch_synth #(.SAMPLE_PERIOD(4), .PHASE_WIDTH(16), .INC_MULT(256),
                .ATTACK_STEP(255), .RELEASE_STEP(64)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .freq_in(freq), .freq_in_valid(fvalid),
    .wave_sel(wsel), .audio_out(audio[0]), .audio_out_valid(avalid[0]), .busy(busy_o[0]));

  pitch_synth #(.SAMPLE_PERIOD(4)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .freq_in(freq), .freq_in_valid(fvalid),
    .wave_sel(wsel), .audio_out(audio[1]), .audio_out_valid(avalid[1]), .busy(busy_o[1]));

  pitch_synth dut_c (
    .clk_in(clk), .rst_in(rst_n), .freq_in(freq), .freq_in_valid(fvalid_c),
    .wave_sel(wsel), .audio_out(audio[2]), .audio_out_valid(avalid[2]), .busy(busy_o[2]));

  localparam int M_IDLE = 0, M_ATT = 1, M_SUS = 2, M_REL = 3;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         per[3], pw[3], mult[3], astep[3], rstep[3];
  int         e[3], env[3], st[3], nxt_out[3];
  longint     inc[3], pinc[3], phase[3];
  bit         pend[3], pon[3], nxt_v[3];
  logic [7:0] exp_audio[3];
  logic       exp_valid[3], exp_busy[3];

  function automatic int wave(input logic [1:0] w, input int p);
    case (w)
      2'd0:    return (p >= 128) ? -127 : 127;
      2'd1:    return p - 128;
      2'd2:    return (p < 128) ? 2 * p - 128 : 383 - 2 * p;
      default: return 0;
    endcase
  endfunction

  function automatic int floor_div256(input int x);
    if (x >= 0) return x / 256;
    return -((-x + 255) / 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: advance every instance by one clock edge using the current inputs.
  task automatic model_edge();
    bit     fv, tk;
    int     p, s;
    longint mask;
    for (int i = 0; i < 3; i++) begin
      fv   = (i == 2) ? fvalid_c : fvalid;
      mask = (longint'(1) << pw[i]) - 1;
      if (!rst_n) begin
        e[i] = 0; env[i] = 0; st[i] = M_IDLE; inc[i] = 0; pinc[i] = 0; phase[i] = 0;
        pend[i] = 0; pon[i] = 0; nxt_v[i] = 0;
        exp_audio[i] = 8'd128; exp_valid[i] = 1'b0; exp_busy[i] = 1'b0;
        continue;
      end
      exp_valid[i] = nxt_v[i];
      if (nxt_v[i]) exp_audio[i] = 8'(nxt_out[i]);
      nxt_v[i] = 0;
      tk = ((e[i] % per[i]) == per[i] - 1);
      e[i]++;
      if (tk) begin
        if (pend[i]) begin
          if (pon[i]) begin
            inc[i] = pinc[i];
            if (st[i] == M_IDLE || st[i] == M_REL) st[i] = M_ATT;
          end else if (st[i] == M_ATT || st[i] == M_SUS) begin
            st[i] = M_REL;
          end
        end
        if (st[i] == M_IDLE) env[i] = 0;
        else if (st[i] == M_ATT) env[i] = (env[i] + astep[i] > 255) ? 255 : env[i] + astep[i];
        else if (st[i] == M_REL) env[i] = (env[i] - rstep[i] < 0) ? 0 : env[i] - rstep[i];
        if (st[i] == M_ATT && env[i] == 255) st[i] = M_SUS;
        if (st[i] == M_REL && env[i] == 0) st[i] = M_IDLE;
        phase[i] = (st[i] == M_IDLE) ? 0 : ((phase[i] + inc[i]) & mask);
        p = int'(phase[i] >> (pw[i] - 8));
        s = wave(wsel, p);
        nxt_out[i] = 128 + floor_div256(s * env[i]);
        nxt_v[i] = 1;
        exp_busy[i] = (st[i] != M_IDLE);
      end
      if (fv) begin
        pend[i] = 1;
        pon[i]  = (freq > 0);
        pinc[i] = (freq > 0) ? (((longint'(freq) * mult[i]) >> 8) & mask) : 0;
      end else if (tk) begin
        pend[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("audio%0d", i), 32'(audio[i]), 32'(exp_audio[i]));
      chk($sformatf("valid%0d", i), 32'(avalid[i]), 32'(exp_valid[i]));
      chk($sformatf("busy%0d", i), 32'(busy_o[i]), 32'(exp_busy[i]));
    end
  endtask

  task automatic get_sample(output int v);
    bit got;
    got = 0;
    v   = -1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (avalid[0] === 1'b1) begin
        got = 1;
        v   = int'(audio[0]);
        break;
      end
    end
    chk("sample_seen", 32'(got), 32'd1);
  endtask

  // Park just past a sample pulse so the next edge is neither a tick nor a pulse.
  task automatic align();
    for (int k = 0; k < 8; k++) begin
      if (e[0] % per[0] == 2) break;
      step();
    end
  endtask

  task automatic strobe(input int f);
    freq = f; fvalid = 1'b1;
    step();
    fvalid = 1'b0;
  endtask

  initial begin
    int v, first_c, second_c;
    per   = '{4, 4, 2272};
    pw    = '{16, 24, 24};
    mult  = '{256, 97582, 97582};
    astep = '{255, 8, 8};
    rstep = '{64, 8, 8};
    rst_n = 1'b0; fvalid = 1'b0; fvalid_c = 1'b0; freq = 0; wsel = 2'd1;

    // Idle after reset: silence, sample pulses every 2272 cycles on the default instance.
    repeat (5) step();
    rst_n = 1'b1;
    first_c = -1; second_c = -1;
    for (int k = 1; k <= 2 * 2272 + 4; k++) begin
      step();
      if (avalid[2] === 1'b1) begin
        if (first_c < 0) first_c = k;
        else if (second_c < 0) second_c = k;
      end
    end
    chk("idle_first_pulse", 32'(first_c), 32'd2273);
    chk("idle_second_pulse", 32'(second_c), 32'd4545);

    // Saw attack from silence.
    align(); wsel = 2'd1; strobe(4096);
    get_sample(v); chk("saw_s0", 32'(v), 32'd16);
    get_sample(v); chk("saw_s1", 32'(v), 32'd32);
    get_sample(v); chk("saw_s2", 32'(v), 32'd48);
    chk("saw_busy", 32'(busy_o[0]), 32'd1);

    // Square from phase zero.
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    align(); wsel = 2'd0; strobe(16384);
    get_sample(v); chk("sq_s0", 32'(v), 32'd254);
    get_sample(v); chk("sq_s1", 32'(v), 32'd1);
    get_sample(v); chk("sq_s2", 32'(v), 32'd1);
    get_sample(v); chk("sq_s3", 32'(v), 32'd254);

    // Release from sustain.
    align(); strobe(0);
    get_sample(v); get_sample(v); get_sample(v);
    chk("rel_busy3", 32'(busy_o[0]), 32'd1);
    get_sample(v);
    chk("rel_out4", 32'(v), 32'd128);
    chk("rel_busy4", 32'(busy_o[0]), 32'd0);
    repeat (12) step();

    // Note on, let the slow instance reach sustain, then release and retrigger.
    align(); wsel = 2'd2; strobe(8192);
    repeat (160) step();
    align(); strobe(0);
    get_sample(v); get_sample(v);
    strobe(8192);
    get_sample(v);
    chk("retrig_busy", 32'(busy_o[0]), 32'd1);
    repeat (20) step();

    // Strobe on the tick cycle itself.
    for (int k = 0; k < 8; k++) begin
      if (e[0] % per[0] == per[0] - 1) break;
      step();
    end
    wsel = 2'd1; strobe(2000);
    repeat (16) step();

    // Two strobes inside one sample period: the later wins.
    align(); strobe(1000); strobe(2000);
    repeat (24) step();

    // Reset mid-note.
    rst_n = 1'b0; step();
    chk("rst_audio", 32'(audio[0]), 32'd128);
    chk("rst_valid", 32'(avalid[0]), 32'd0);
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    rst_n = 1'b1;
    repeat (20) step();
    get_sample(v); chk("post_rst_silent", 32'(v), 32'd128);

    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      wsel   = 2'($urandom_range(0, 3));
      fvalid = ($urandom_range(0, 5) == 0);
      freq   = $signed(32'($urandom_range(0, 6000))) - 32'sd1000;
      rst_n  = ($urandom_range(0, 299) != 0);
      step();
    end
    fvalid = 1'b0; rst_n = 1'b1;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
